// File: rtl/pc_fetch.sv
// pc_fetch: instruction fetch stage holding the PC, issuing memory reads and presenting one instruction to decode.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   pcload, pcaddr    redirect request and target (low two target bits ignored)
//   stall             decode cannot accept the presented instruction
//   imem_req/addr     instruction memory read request and word-aligned address
//   imem_ack/rdata    read completion and instruction word
//   instr, instr_pc   instruction presented to decode and its address
//   instr_valid       instr/instr_pc are valid
//   pc                current fetch PC
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcload,
    input  logic [31:0] pcaddr,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic [31:0] pc
);
    typedef enum logic {S_REQ, S_OUT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_valid;
    logic        r_pend;
    logic [31:0] r_pend_addr;
    logic [31:0] w_target;

    assign w_target    = pcaddr & 32'hFFFF_FFFC;
    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;
    assign pc          = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_REQ;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_instr_pc  <= '0;
            r_valid     <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else if (r_state == S_REQ) begin
            if (imem_ack) begin
                if (pcload || r_pend) begin
                    // the returning word belongs to the abandoned path: drop it and refetch
                    r_pc   <= pcload ? w_target : r_pend_addr;
                    r_pend <= 1'b0;
                end else begin
                    r_instr    <= imem_rdata;
                    r_instr_pc <= r_pc;
                    r_pc       <= r_pc + 32'd4;
                    r_valid    <= 1'b1;
                    r_state    <= S_OUT;
                end
            end else if (pcload) begin
                // address must stay stable until ack, so the redirect waits here
                r_pend      <= 1'b1;
                r_pend_addr <= w_target;
            end
        end else begin
            if (pcload) begin
                r_pc    <= w_target;
                r_valid <= 1'b0;
                r_state <= S_REQ;
            end else if (!stall) begin
                r_valid <= 1'b0;
                r_state <= S_REQ;
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: scoreboard bench for pc_fetch with directed fetch, stall, redirect, reset and wrap vectors.
module tb_pc_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pcload = 1'b0;
    logic [31:0] pcaddr = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] pc;

    logic        b_req;
    logic [31:0] b_addr;
    logic        b_ack = 1'b0;
    logic [31:0] b_rdata = '0;
    logic [31:0] b_instr;
    logic [31:0] b_instr_pc;
    logic        b_valid;
    logic [31:0] b_pc;

    int passed = 0;
    int total = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    pc_fetch dut (
        .clk(clk), .rst(rst), .pcload(pcload), .pcaddr(pcaddr), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .pc(pc)
    );

    pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .pcload(1'b0), .pcaddr(32'h0), .stall(1'b0),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack), .imem_rdata(b_rdata),
        .instr(b_instr), .instr_pc(b_instr_pc), .instr_valid(b_valid), .pc(b_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Acknowledge the outstanding request at address a and expect it to be presented.
    task automatic do_ack(input logic [31:0] a);
        chk("req_before_ack", {31'b0, imem_req}, 32'd1);
        chk("req_addr", imem_addr, a);
        imem_ack = 1'b1;
        imem_rdata = 32'h2000_0000 + a;
        sb.push_back({32'h2000_0000 + a, a});
        @(negedge clk);
        imem_ack = 1'b0;
        chk("valid_after_ack", {31'b0, instr_valid}, 32'd1);
        chk("req_in_out", {31'b0, imem_req}, 32'd0);
    endtask

    // Monitor: every new presentation of an instruction pops one expected entry.
    initial begin
        logic prev_v;
        logic [63:0] e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (instr_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr);
                end else begin
                    e = sb.pop_front();
                    chk("sb_instr", instr, e[63:32]);
                    chk("sb_instr_pc", instr_pc, e[31:0]);
                end
            end
            prev_v = instr_valid;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'd1);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_pc", pc, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_addr", imem_addr, 32'd0);
        // sequential fetch at two cycles per instruction
        do_ack(32'h0);
        @(negedge clk);
        do_ack(32'h4);
        @(negedge clk);
        do_ack(32'h8);
        @(negedge clk);
        do_ack(32'hC);
        // stall hold, with a stray ack in OUT that must be ignored
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            imem_ack = (i == 2);
            imem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            imem_ack = 1'b0;
            chk("stall_instr", instr, 32'h2000_000C);
            chk("stall_instr_pc", instr_pc, 32'hC);
            chk("stall_pc", pc, 32'h10);
            chk("stall_req", {31'b0, imem_req}, 32'd0);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("resume_addr", imem_addr, 32'h10);
        // late redirect, second pcload overwrites the first pending target
        pcload = 1'b1;
        pcaddr = 32'h0000_5000;
        @(negedge clk);
        pcaddr = 32'h1234_5678;
        chk("pend_addr_hold", imem_addr, 32'h10);
        @(negedge clk);
        pcload = 1'b0;
        chk("pend_addr_hold2", imem_addr, 32'h10);
        @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0001;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("late_valid", {31'b0, instr_valid}, 32'd0);
        chk("late_req", {31'b0, imem_req}, 32'd1);
        chk("late_addr", imem_addr, 32'h1234_5678);
        // redirect coincident with ack
        pcload = 1'b1;
        pcaddr = 32'h8765_4321;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0002;
        @(negedge clk);
        pcload = 1'b0;
        imem_ack = 1'b0;
        chk("coinc_valid", {31'b0, instr_valid}, 32'd0);
        chk("coinc_addr", imem_addr, 32'h8765_4320);
        do_ack(32'h8765_4320);
        // redirect in OUT while stalled
        stall = 1'b1;
        pcload = 1'b1;
        pcaddr = 32'h0000_0100;
        @(negedge clk);
        stall = 1'b0;
        pcload = 1'b0;
        chk("out_redir_valid", {31'b0, instr_valid}, 32'd0);
        chk("out_redir_addr", imem_addr, 32'h100);
        do_ack(32'h100);
        @(negedge clk);
        // reset mid-request, then the late ack is a fresh fetch at RESET_PC
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        do_ack(32'h0);
        @(negedge clk);
        // wrap instance
        chk("wrap_req", {31'b0, b_req}, 32'd1);
        chk("wrap_first_addr", b_addr, 32'hFFFF_FFFC);
        b_ack = 1'b1;
        b_rdata = 32'hCAFE_0001;
        @(negedge clk);
        b_ack = 1'b0;
        chk("wrap_instr_pc", b_instr_pc, 32'hFFFF_FFFC);
        chk("wrap_instr", b_instr, 32'hCAFE_0001);
        chk("wrap_pc", b_pc, 32'h0);
        @(negedge clk);
        chk("wrap_next_addr", b_addr, 32'h0);
        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning the synchronous, active-high reset.
REQ-004 The block SHALL have port pcload, input, 1, meaning redirect request from the PC address MUX.
REQ-005 The block SHALL have port pcaddr, input, 32, meaning redirect target from the PC address MUX.
REQ-006 The block SHALL have port stall, input, 1, meaning the decode stage cannot accept the presented instruction.
REQ-007 The block SHALL have port imem_req, output, 1, meaning an instruction memory read is requested.
REQ-008 The block SHALL have port imem_addr, output, 32, meaning the read address, word aligned.
REQ-009 The block SHALL have port imem_ack, input, 1, meaning imem_rdata is valid this cycle.
REQ-010 The block SHALL have port imem_rdata, input, 32, meaning the instruction word read.
REQ-011 The block SHALL have port instr, output, 32, meaning the instruction presented to decode.
REQ-012 The block SHALL have port instr_pc, output, 32, meaning the address of instr.
REQ-013 The block SHALL have port instr_valid, output, 1, meaning instr/instr_pc are valid.
REQ-014 The block SHALL have port pc, output, 32, meaning the current fetch PC register.

Function
REQ-015 The block SHALL implement two states: REQ (memory read outstanding) and OUT (instruction held for decode).
REQ-016 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc, both held stable until imem_ack.
REQ-017 In OUT, imem_req SHALL be 0 and instr_valid SHALL be 1.
REQ-018 On imem_ack in REQ with no redirect pending and pcload=0, the block SHALL latch instr<=imem_rdata, instr_pc<=pc, set pc<=pc+4, and enter OUT next cycle.
REQ-019 The pc+4 addition SHALL be modulo 2^32: 32'hFFFFFFFC SHALL wrap to 32'h00000000.
REQ-020 In OUT with stall=1 and pcload=0, the block SHALL hold instr, instr_pc, instr_valid and pc unchanged.
REQ-021 In OUT with stall=0 and pcload=0, the block SHALL clear instr_valid and enter REQ next cycle.
REQ-022 In OUT with pcload=1, regardless of stall, the block SHALL set pc<=pcaddr, clear instr_valid, and enter REQ next cycle.
REQ-023 pcaddr[1:0] SHALL be ignored: the loaded pc SHALL be {pcaddr[31:2],2'b00}.
REQ-024 In REQ with pcload=1 and imem_ack=0, the block SHALL record the target in a pending-redirect register, keeping imem_addr unchanged.
REQ-025 A later pcload while a redirect is pending SHALL overwrite the pending target (latest wins).
REQ-026 On imem_ack in REQ with a redirect pending or pcload=1, the block SHALL discard imem_rdata, keep instr_valid=0, and set pc to the target, pcload's pcaddr taking priority over the pending target.
REQ-027 That discarding ack SHALL clear the pending redirect and leave the block in REQ, issuing a request at the new pc the next cycle.
REQ-028 imem_ack while in OUT SHALL be ignored.
REQ-029 Minimum fetch throughput SHALL be one instruction per two cycles: ack, then OUT, then REQ.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL set pc=RESET_PC, state=REQ, instr_valid=0, instr=0, instr_pc=0 and clear the pending redirect, overriding all other inputs.
REQ-031 In the first cycle after reset deasserts, imem_req SHALL be 1 with imem_addr=RESET_PC.
REQ-032 Reset asserted mid-request or mid-stall SHALL abandon the request or instruction, and any later imem_ack for it SHALL be treated as a fresh ack at RESET_PC.

Verification
REQ-033 The bench SHALL cover sequential fetch: reset, ack every request with data 32'h2000_0000+addr, stall=0 -> instr_pc sequence 0,4,8,C, each with the matching instr.
REQ-034 The bench SHALL cover stall hold: stall=1 for 5 cycles in OUT -> instr, instr_pc and pc constant, imem_req=0, and fetch resumes at instr_pc+4 after stall drops.
REQ-035 The bench SHALL cover late redirect: pcload=1 with pcaddr=32'h12345678 in REQ, ack 3 cycles later -> no instr_valid for that data, next imem_addr=32'h12345678.
REQ-036 The bench SHALL cover redirect coincident with ack: pcload=1 with pcaddr=32'h87654321 and imem_ack in the same cycle -> data discarded, next imem_addr=32'h87654320.
REQ-037 The bench SHALL cover redirect in OUT with stall=1: pcaddr=32'h00000100 -> instr_valid=0 next cycle, imem_addr=32'h00000100.
REQ-038 The bench SHALL cover wrap: RESET_PC=32'hFFFFFFFC, one ack -> instr_pc=32'hFFFFFFFC, next imem_addr=32'h00000000.
